map_ram_arbiter: RTL
====================

# map_ram_arbiter

Arbitrates the single-port tile-map RAM (36 rows × 28 columns, 8-bit tile codes) between two requesters. The first is the VGA renderer's memory address path, which reads tiles while pixels are being drawn. The second is the game-logic engine, which reads and writes tiles, for example to erase pellets. The arbiter converts (row, col) to a linear RAM address and gives the renderer strict priority during active display. It shares the RAM round-robin during blanking, flags game-side starvation, and returns read data with a fixed latency.

## Interface
Parameters:
- ROWS, 36, map rows
- COLS, 28, map columns
- DW, 8, tile data width
- STALL_LIMIT, 800, consecutive waiting cycles before o_g_stall asserts

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_show_en  in  1  1 during VGA active display
- i_r_req  in  1  renderer read request, held until granted
- i_r_row / i_r_col  in  6 / 5  renderer tile coordinate
- o_r_gnt  out  1  renderer request accepted this cycle
- o_r_rvalid  out  1  renderer read data valid
- o_r_rdata  out  DW  renderer read data
- i_g_req  in  1  game request, held until granted
- i_g_we  in  1  1 = write, 0 = read
- i_g_row / i_g_col  in  6 / 5  game tile coordinate
- i_g_wdata  in  DW  game write data
- o_g_gnt  out  1  game request accepted this cycle
- o_g_rvalid  out  1  game read completion, or out-of-range completion
- o_g_rdata  out  DW  game read data
- o_g_err  out  1  out-of-range completion marker
- o_g_stall  out  1  game request starved for at least STALL_LIMIT cycles
- o_ram_en, o_ram_we  out  1  RAM access strobe and write enable
- o_ram_addr  out  10  linear address
- o_ram_wdata  out  DW  RAM write data
- i_ram_rdata  in  DW  RAM read data, valid one cycle after the access edge

## Operation
- **Address computation:** addr = row*28 + col, implemented as (row<<4)+(row<<3)+(row<<2)+col, 10 bits. The range is 0..1007.
- **Out of range:** a coordinate is out of range when row ≥ ROWS or col ≥ COLS.
- **Arbitration**, decided combinationally each cycle; o_*_gnt is combinational:
  - If i_show_en=1 and i_r_req=1, the renderer wins.
  - If i_show_en=1 and i_r_req=0, the game wins when it is requesting.
  - If i_show_en=0 and both are requesting, round-robin applies. The requester that did not win last time gets the grant.
  - The round-robin pointer updates only on contended grants. After reset the pointer favours the game.
- **Single requester:** a lone requester is granted the same cycle regardless of i_show_en.
- **Grant exclusivity:** at most one grant per cycle, and one access per grant.
- **Access cycle:** the granted command is registered onto o_ram_* in cycle N+1 with o_ram_en=1. o_ram_we and o_ram_wdata are driven only for game writes.
- **Out-of-range grants:**
  - The grant is still issued, but o_ram_en stays 0.
  - The completion returns rdata 0x00.
  - For the game, o_g_err=1 is asserted together with o_g_rvalid. This applies to out-of-range reads and writes alike.
  - For the renderer there is no error output, only rvalid with 0x00 (blank tile).
- **Writes:** in-range writes produce no rvalid.
- **Completion tags:** a two-stage pipeline tag (owner, read, err) tracks each access to its completion. o_*_rdata equals i_ram_rdata when the tag is in range and 0 otherwise. Both rdata outputs are 0 when not valid.
- **Stall counter** (10+ bits, saturating at STALL_LIMIT):
  - Increments each cycle with i_g_req=1 and o_g_gnt=0.
  - Clears on a game grant or when i_g_req=0.
  - o_g_stall is registered, and is 1 while the counter equals STALL_LIMIT.

## Timing
- Grant in cycle N, RAM command in cycle N+1, o_*_rvalid, o_*_rdata and o_g_err in cycle N+2 for one cycle.
- Back-to-back grants every cycle are allowed and give full throughput. Completions stay in order.
- Reset values: all outputs are 0, the pipeline tags are cleared, the stall counter is 0, and the RR pointer is set to game.
- Reset during an in-flight access: the access is discarded, and no rvalid appears after reset is released.
- i_show_en toggling mid-stream changes priority only for new decisions; in-flight completions are unaffected.
- o_g_stall rises in the cycle after the counter reaches STALL_LIMIT. It falls in the cycle after the grant.

## Test plan
- **Renderer read:** RAM addr 0 preloaded with 0x1A; renderer reads row 0, col 0 at cycle N -> o_r_gnt=1 at N; o_ram_en=1 and addr=0 at N+1; o_r_rvalid=1 and rdata=0x1A at N+2.
- **Display priority and starvation:** STALL_LIMIT=8, i_show_en=1, both requesting for 12 cycles -> o_r_gnt every cycle, o_g_gnt=0, o_g_stall=1 from cycle 9. Then drop i_show_en -> game granted that cycle, o_g_stall=0 the next cycle.
- **Blanking round-robin:** i_show_en=0, both requesting continuously from reset -> grant sequence G,R,G,R,G,R.
- **Write then read back:** game write row 35, col 27, data 0x5C -> o_ram_addr=1007, we=1, wdata=0x5C at N+1, no rvalid. A subsequent game read of the same tile returns 0x5C.
- **Out-of-range:** game read row 36, col 0 -> gnt; o_ram_en=0; at N+2 o_g_rvalid=1, o_g_err=1, rdata=0x00. Renderer col 28 -> o_r_rvalid with 0x00.
- **Reset mid-access:** i_rst_n low in the cycle after a renderer grant -> all outputs 0 immediately. No o_r_rvalid after release, and the next contended grant goes to the game.

Source files
------------

// File: rtl/map_ram_arbiter.sv
// Tile-map RAM arbiter: renderer vs. game engine on a single-port RAM.
// Grants are combinational, the RAM command is registered, and completions return two cycles after grant.
module map_ram_arbiter #(
    parameter int ROWS        = 36,
    parameter int COLS        = 28,
    parameter int DW          = 8,
    parameter int STALL_LIMIT = 800
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_show_en,

    input  logic          i_r_req,
    input  logic [5:0]    i_r_row,
    input  logic [4:0]    i_r_col,
    output logic          o_r_gnt,
    output logic          o_r_rvalid,
    output logic [DW-1:0] o_r_rdata,

    input  logic          i_g_req,
    input  logic          i_g_we,
    input  logic [5:0]    i_g_row,
    input  logic [4:0]    i_g_col,
    input  logic [DW-1:0] i_g_wdata,
    output logic          o_g_gnt,
    output logic          o_g_rvalid,
    output logic [DW-1:0] o_g_rdata,
    output logic          o_g_err,
    output logic          o_g_stall,

    output logic          o_ram_en,
    output logic          o_ram_we,
    output logic [9:0]    o_ram_addr,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata
);

    localparam int CNT_W = ($clog2(STALL_LIMIT + 1) > 10) ? $clog2(STALL_LIMIT + 1) : 10;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT);

    // row*28 + col built from shifts so no multiplier is inferred
    function automatic logic [9:0] tile_addr(input logic [5:0] row, input logic [4:0] col);
        logic [9:0] r10;
        r10 = {4'b0, row};
        return (r10 << 4) + (r10 << 3) + (r10 << 2) + {5'b0, col};
    endfunction

    function automatic logic in_range(input logic [5:0] row, input logic [4:0] col);
        return (int'(row) < ROWS) && (int'(col) < COLS);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt >= CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
    endfunction

    logic             r_ok;
    logic             g_ok;
    logic             contend;
    logic             r_gnt;
    logic             g_gnt;

    logic             rr_game_q;
    logic             rr_game_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             stall_q;

    logic             ram_en_p1_q,    ram_en_p1_d;
    logic             ram_we_p1_q,    ram_we_p1_d;
    logic [9:0]       ram_addr_p1_q,  ram_addr_p1_d;
    logic [DW-1:0]    ram_wdata_p1_q, ram_wdata_p1_d;
    logic             tag_vld_p1_q,   tag_vld_p1_d;
    logic             tag_game_p1_q,  tag_game_p1_d;
    logic             tag_err_p1_q,   tag_err_p1_d;

    logic             r_rvalid_p2_q;
    logic             g_rvalid_p2_q;
    logic             err_p2_q;
    logic             g_err_p2_q;

    assign r_ok    = in_range(i_r_row, i_r_col);
    assign g_ok    = in_range(i_g_row, i_g_col);
    assign contend = i_r_req & i_g_req;

    // Grants are suppressed while reset is held so every output reads 0 immediately
    always_comb begin
        r_gnt = 1'b0;
        g_gnt = 1'b0;
        if (i_rst_n) begin
            if (contend) begin
                if (i_show_en) begin
                    r_gnt = 1'b1;
                end else if (rr_game_q) begin
                    g_gnt = 1'b1;
                end else begin
                    r_gnt = 1'b1;
                end
            end else begin
                r_gnt = i_r_req;
                g_gnt = i_g_req;
            end
        end
    end

    // Pointer moves only when both were asking; it then favours whoever lost
    always_comb begin
        rr_game_d = rr_game_q;
        if (contend && (r_gnt || g_gnt)) begin
            rr_game_d = r_gnt;
        end
    end

    always_comb begin
        stall_cnt_d = '0;
        if (i_g_req && !g_gnt) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    // Stage p0 -> p1: RAM command and completion tag
    always_comb begin
        ram_en_p1_d    = (r_gnt & r_ok) | (g_gnt & g_ok);
        ram_we_p1_d    = g_gnt & g_ok & i_g_we;
        ram_addr_p1_d  = '0;
        ram_wdata_p1_d = '0;
        if (r_gnt && r_ok) begin
            ram_addr_p1_d = tile_addr(i_r_row, i_r_col);
        end else if (g_gnt && g_ok) begin
            ram_addr_p1_d = tile_addr(i_g_row, i_g_col);
        end
        if (ram_we_p1_d) begin
            ram_wdata_p1_d = i_g_wdata;
        end
        tag_vld_p1_d  = r_gnt | (g_gnt & (~i_g_we | ~g_ok));
        tag_game_p1_d = g_gnt;
        tag_err_p1_d  = (r_gnt & ~r_ok) | (g_gnt & ~g_ok);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_game_q      <= 1'b1;
            stall_cnt_q    <= '0;
            stall_q        <= 1'b0;
            ram_en_p1_q    <= 1'b0;
            ram_we_p1_q    <= 1'b0;
            ram_addr_p1_q  <= '0;
            ram_wdata_p1_q <= '0;
            tag_vld_p1_q   <= 1'b0;
            tag_game_p1_q  <= 1'b0;
            tag_err_p1_q   <= 1'b0;
            r_rvalid_p2_q  <= 1'b0;
            g_rvalid_p2_q  <= 1'b0;
            err_p2_q       <= 1'b0;
            g_err_p2_q     <= 1'b0;
        end else begin
            rr_game_q      <= rr_game_d;
            stall_cnt_q    <= stall_cnt_d;
            stall_q        <= (stall_cnt_d == CNT_MAX);
            ram_en_p1_q    <= ram_en_p1_d;
            ram_we_p1_q    <= ram_we_p1_d;
            ram_addr_p1_q  <= ram_addr_p1_d;
            ram_wdata_p1_q <= ram_wdata_p1_d;
            tag_vld_p1_q   <= tag_vld_p1_d;
            tag_game_p1_q  <= tag_game_p1_d;
            tag_err_p1_q   <= tag_err_p1_d;
            // Stage p1 -> p2: completion flags line up with RAM read data
            r_rvalid_p2_q  <= tag_vld_p1_q & ~tag_game_p1_q;
            g_rvalid_p2_q  <= tag_vld_p1_q & tag_game_p1_q;
            err_p2_q       <= tag_vld_p1_q & tag_err_p1_q;
            g_err_p2_q     <= tag_vld_p1_q & tag_game_p1_q & tag_err_p1_q;
        end
    end

    assign o_r_gnt     = r_gnt;
    assign o_g_gnt     = g_gnt;
    assign o_g_stall   = stall_q;
    assign o_ram_en    = ram_en_p1_q;
    assign o_ram_we    = ram_we_p1_q;
    assign o_ram_addr  = ram_addr_p1_q;
    assign o_ram_wdata = ram_wdata_p1_q;

    // Out-of-range completions return a blank tile instead of stale RAM data
    assign o_r_rvalid  = r_rvalid_p2_q;
    assign o_r_rdata   = (r_rvalid_p2_q && !err_p2_q) ? i_ram_rdata : '0;
    assign o_g_rvalid  = g_rvalid_p2_q;
    assign o_g_rdata   = (g_rvalid_p2_q && !err_p2_q) ? i_ram_rdata : '0;
    assign o_g_err     = g_err_p2_q;

endmodule
